// File: rtl/mem_pkg.sv
// Shared definitions for the data memory: byte-enable patterns, bus direction
// encoding and the init/run state type.
package mem_pkg;

    localparam logic [3:0] BE_NONE = 4'b0000;
    localparam logic [3:0] BE_B0   = 4'b0001;
    localparam logic [3:0] BE_B1   = 4'b0010;
    localparam logic [3:0] BE_B2   = 4'b0100;
    localparam logic [3:0] BE_B3   = 4'b1000;
    localparam logic [3:0] BE_HLO  = 4'b0011;
    localparam logic [3:0] BE_HHI  = 4'b1100;
    localparam logic [3:0] BE_W    = 4'b1111;

    localparam logic MEM_READ  = 1'b1;
    localparam logic MEM_WRITE = 1'b0;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Only naturally aligned byte, halfword and word stores exist on the bus.
    function automatic logic be_is_legal(input logic [3:0] be);
        case (be)
            BE_B0, BE_B1, BE_B2, BE_B3, BE_HLO, BE_HHI, BE_W: return 1'b1;
            default:                                          return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_addr_check.sv
// Combinational decode of a bus request: word index, range check and
// byte-enable legality (reads accept any byte-enable value).
module mem_addr_check
    import mem_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic [31:0]                      mem_addr,
    input  logic [3:0]                       mem_byte_en,
    input  logic                             mem_rw_mode,
    output logic [$clog2(DEPTH_WORDS)-1:0]   idx,
    output logic                             in_range,
    output logic                             be_legal
);
    localparam int          AW   = $clog2(DEPTH_WORDS);
    localparam logic [31:0] SPAN = 32'(4 * DEPTH_WORDS);

    logic [31:0] offs;

    always_comb begin
        offs     = mem_addr - BASE_ADDR;
        in_range = (offs < SPAN);
        idx      = offs[AW+1:2];
        be_legal = (mem_rw_mode == MEM_READ) || be_is_legal(mem_byte_en);
    end

endmodule

// File: rtl/data_mem.sv
// Word-organised data memory with byte-masked writes, one-cycle registered
// reads and a post-reset clearing sequencer.
module data_mem
    import mem_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        mem_rw_mode,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_write_data,
    input  logic [3:0]  mem_byte_en,
    output logic [31:0] mem_read_data,
    output logic        mem_busy,
    output logic        mem_err
);
    localparam int AW = $clog2(DEPTH_WORDS);

    logic [31:0]   mem [DEPTH_WORDS];

    state_t        state_q, state_d;
    logic [AW-1:0] clr_idx_q, clr_idx_d;
    logic [31:0]   rd_data_q;
    logic          err_q, err_d;

    logic [AW-1:0] idx;
    logic          in_range;
    logic          be_legal;

    logic [AW-1:0] wr_idx;
    logic [31:0]   wr_data;
    logic [3:0]    wr_be;

    mem_addr_check #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .BASE_ADDR   (BASE_ADDR)
    ) u_addr_check (
        .mem_addr    (mem_addr),
        .mem_byte_en (mem_byte_en),
        .mem_rw_mode (mem_rw_mode),
        .idx         (idx),
        .in_range    (in_range),
        .be_legal    (be_legal)
    );

    // The single write port is shared between the clearing sequencer and the bus.
    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        err_d     = 1'b0;
        wr_idx    = clr_idx_q;
        wr_data   = '0;
        wr_be     = BE_NONE;
        case (state_q)
            INIT: begin
                wr_be     = BE_W;
                clr_idx_d = clr_idx_q + 1'b1;
                if (clr_idx_q == AW'(DEPTH_WORDS - 1)) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                wr_idx  = idx;
                wr_data = mem_write_data;
                if (mem_rw_mode == MEM_READ) begin
                    err_d = !in_range;
                end else if (mem_byte_en != BE_NONE) begin
                    if (in_range && be_legal) begin
                        wr_be = mem_byte_en;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            default: state_d = INIT;
        endcase
    end

    // Gating with i_rst drops a write that coincides with reset assertion.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_be[b]) begin
                    mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q   <= INIT;
            clr_idx_q <= '0;
            rd_data_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
            err_q     <= err_d;
            if (state_q == RUN && mem_rw_mode == MEM_READ) begin
                rd_data_q <= in_range ? mem[idx] : 32'h0;
            end
        end
    end

    assign mem_read_data = rd_data_q;
    assign mem_busy      = (state_q == INIT);
    assign mem_err       = err_q;

endmodule

// File: tb/tb_data_mem.sv
// Randomized and directed checks of data_mem against a word-array reference
// model; one line is printed per bus transaction.
module tb_data_mem;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        mem_rw_mode;
    logic [31:0] mem_addr;
    logic [31:0] mem_write_data;
    logic [3:0]  mem_byte_en;
    logic [31:0] mem_read_data;
    logic        mem_busy;
    logic        mem_err;

    data_mem #(
        .DEPTH_WORDS (1024),
        .BASE_ADDR   (32'h0000_0000)
    ) dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .mem_rw_mode    (mem_rw_mode),
        .mem_addr       (mem_addr),
        .mem_write_data (mem_write_data),
        .mem_byte_en    (mem_byte_en),
        .mem_read_data  (mem_read_data),
        .mem_busy       (mem_busy),
        .mem_err        (mem_err)
    );

    always #5 i_clk = ~i_clk;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] ref_mem [1024];
    logic [31:0] exp_rd;
    logic        exp_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic logic be_ok(input logic [3:0] be);
        return be inside {4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};
    endfunction

    // One bus cycle: drive at negedge, update the model at the edge, compare 1 time unit later.
    task automatic bus(input logic rw, input logic [31:0] addr, input logic [31:0] data,
                       input logic [3:0] be);
        logic        inr;
        logic [31:0] mask;
        @(negedge i_clk);
        mem_rw_mode    = rw;
        mem_addr       = addr;
        mem_write_data = data;
        mem_byte_en    = be;
        @(posedge i_clk);
        inr     = (addr < 32'h0000_1000);
        exp_err = 1'b0;
        if (rw) begin
            if (inr) exp_rd = ref_mem[addr[11:2]];
            else begin
                exp_rd  = 32'h0;
                exp_err = 1'b1;
            end
        end else if (be != 4'b0000) begin
            if (inr && be_ok(be)) begin
                mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
                ref_mem[addr[11:2]] = (ref_mem[addr[11:2]] & ~mask) | (data & mask);
            end else begin
                exp_err = 1'b1;
            end
        end
        #1;
        $display("%s addr=%h wdata=%h be=%b -> rd=%h err=%b", rw ? "RD" : "WR",
                 addr, data, be, mem_read_data, mem_err);
        chk("rd_data", mem_read_data, exp_rd);
        chk("err", 32'(mem_err), 32'(exp_err));
        chk("busy_run", 32'(mem_busy), 32'h0);
    endtask

    task automatic assert_reset(input int hold);
        @(negedge i_clk);
        i_rst = 1'b0;
        #1;
        chk("rst_busy", 32'(mem_busy), 32'h1);
        chk("rst_rd", mem_read_data, 32'h0);
        chk("rst_err", 32'(mem_err), 32'h0);
        repeat (hold) @(negedge i_clk);
        i_rst = 1'b1;
    endtask

    task automatic wait_init();
        int cnt;
        int bad;
        cnt = 0;
        bad = 0;
        while (cnt < 2000) begin
            @(posedge i_clk);
            #1;
            cnt++;
            if (!mem_busy) break;
            if (mem_read_data !== 32'h0 || mem_err !== 1'b0) bad++;
        end
        $display("init finished after %0d cycles", cnt);
        chk("init_len", 32'(cnt), 32'd1024);
        chk("init_quiet", 32'(bad), 32'd0);
        for (int i = 0; i < 1024; i++) ref_mem[i] = 32'h0;
        exp_rd = 32'h0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [31:0] a;
        int          r;
        i_rst          = 1'b0;
        mem_rw_mode    = 1'b1;
        mem_addr       = 32'h0;
        mem_write_data = 32'h0;
        mem_byte_en    = 4'b0000;
        repeat (3) @(negedge i_clk);
        chk("por_busy", 32'(mem_busy), 32'h1);
        chk("por_rd", mem_read_data, 32'h0);
        chk("por_err", 32'(mem_err), 32'h0);
        i_rst = 1'b1;
        wait_init();

        bus(1'b1, 32'h0000_0000, 32'h0, 4'b0000);
        bus(1'b1, 32'h0000_07FC, 32'h0, 4'b0000);
        bus(1'b1, 32'h0000_0FFC, 32'h0, 4'b0000);

        bus(1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 4'b1111);
        bus(1'b0, 32'h0000_0012, 32'h00AA_0000, 4'b0100);
        bus(1'b0, 32'h0000_0010, 32'h0000_1234, 4'b0011);
        bus(1'b1, 32'h0000_0010, 32'h0, 4'b0000);
        chk("merge_word", mem_read_data, 32'hDEAA_1234);

        bus(1'b0, 32'h0000_1000, 32'hFFFF_FFFF, 4'b1111);
        bus(1'b1, 32'h0000_1000, 32'h0, 4'b0000);
        bus(1'b1, 32'h0000_0000, 32'h0, 4'b0000);
        bus(1'b0, 32'h0000_0020, 32'h1234_5678, 4'b0110);
        bus(1'b1, 32'h0000_0020, 32'h0, 4'b0000);
        bus(1'b0, 32'h0000_0024, 32'h1234_5678, 4'b0000);
        bus(1'b1, 32'h0000_0024, 32'h0, 4'b0000);

        bus(1'b0, 32'h0000_0100, 32'h1111_1111, 4'b1111);
        bus(1'b0, 32'h0000_0104, 32'h2222_2222, 4'b1111);
        bus(1'b0, 32'h0000_0108, 32'h3333_3333, 4'b1111);
        bus(1'b1, 32'h0000_0100, 32'h0, 4'b0000);
        bus(1'b1, 32'h0000_0104, 32'h0, 4'b0000);
        bus(1'b1, 32'h0000_0108, 32'h0, 4'b0000);

        for (int n = 0; n < 500; n++) begin
            r = $urandom_range(0, 9);
            case (r)
                0, 1, 2, 3: a = 32'($urandom_range(0, 15)) * 4 + 32'($urandom_range(0, 3));
                4, 5:       a = 32'($urandom_range(0, 1023)) * 4 + 32'($urandom_range(0, 3));
                6:          a = 32'h0000_0FFC + 32'($urandom_range(0, 7));
                7:          a = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
                default:    a = $urandom;
            endcase
            bus(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)));
        end

        bus(1'b0, 32'h0000_0040, 32'h0000_0055, 4'b1111);
        bus(1'b1, 32'h0000_0040, 32'h0, 4'b0000);
        assert_reset(3);
        wait_init();
        bus(1'b1, 32'h0000_0040, 32'h0, 4'b0000);

        assert_reset(3);
        repeat (500) @(posedge i_clk);
        chk("mid_init_busy", 32'(mem_busy), 32'h1);
        assert_reset(3);
        wait_init();
        bus(1'b1, 32'h0000_0010, 32'h0, 4'b0000);
        bus(1'b1, 32'h0000_0FFC, 32'h0, 4'b0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
